mac_acc_signed: RTL and testbench



---
 rtl/mac_acc_signed.sv | 141 ++++++++++++++
 tb/tb_mac_acc_signed.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_signed.sv
// Signed multiply-accumulate stage: sums ACC_LENGTH products per frame and
// hands one saturated result downstream over a valid/ready handshake.

module mult_lut_signed #(
  parameter int DW = 6
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] p
);

  logic [2*DW-1:0] ext_a;

  assign ext_a = {{DW{a[DW-1]}}, a};

  // Rows of partial products; the sign bit of b carries negative weight.
  always_comb begin
    p = '0;
    for (int i = 0; i < DW - 1; i++) begin
      if (b[i]) p = p + (ext_a << i);
    end
    if (b[DW-1]) p = p - (ext_a << (DW - 1));
  end

endmodule

module mac_acc_signed #(
  parameter int DATA_WIDTH = 6,
  parameter int ACC_LENGTH = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [OUT_WIDTH-1:0]  Q,
  output logic                  OVF
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ACC_W = PW + $clog2(ACC_LENGTH);
  localparam int CNT_W = $clog2(ACC_LENGTH + 1);

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_OUT} state_t;

  state_t                   state;
  logic [PW-1:0]            prod;
  logic signed [PW-1:0]     p_reg;
  logic                     p_vld;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic [OUT_WIDTH-1:0]     q_next;
  logic                     ovf_next;
  logic                     accept;
  logic                     last;

  mult_lut_signed #(.DW(DATA_WIDTH)) u_mult (
    .a (A),
    .b (B),
    .p (prod)
  );

  assign accept   = IN_VALID & IN_READY;
  assign last     = (cnt + CNT_W'(1)) == CNT_W'(ACC_LENGTH);
  assign acc_next = p_vld ? acc + ACC_W'(p_reg) : acc;

  // Clamp only when the accumulator can exceed the output range.
  if (OUT_WIDTH >= ACC_W) begin : g_ext
    assign q_next   = OUT_WIDTH'(acc_next);
    assign ovf_next = 1'b0;
  end else begin : g_sat
    logic [ACC_W-OUT_WIDTH:0] top;

    assign top = acc_next[ACC_W-1:OUT_WIDTH-1];

    always_comb begin
      q_next   = acc_next[OUT_WIDTH-1:0];
      ovf_next = 1'b0;
      if (!(&top) && (|top)) begin
        ovf_next = 1'b1;
        q_next   = acc_next[ACC_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= S_ACC;
      cnt       <= '0;
      acc       <= '0;
      p_reg     <= '0;
      p_vld     <= 1'b0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      Q         <= '0;
      OVF       <= 1'b0;
    end else begin
      p_vld <= accept;
      acc   <= acc_next;
      if (accept) begin
        p_reg <= prod;
        cnt   <= cnt + CNT_W'(1);
      end
      case (state)
        S_ACC: begin
          if (accept && last) begin
            state    <= S_DRAIN;
            IN_READY <= 1'b0;
          end
        end
        // The final product lands in the accumulator on this edge.
        S_DRAIN: begin
          state     <= S_OUT;
          OUT_VALID <= 1'b1;
          Q         <= q_next;
          OVF       <= ovf_next;
        end
        S_OUT: begin
          if (OUT_READY) begin
            state     <= S_ACC;
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            OVF       <= 1'b0;
          end
        end
        default: begin
          state <= S_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_acc_signed.sv
// Directed bench for mac_acc_signed: four instances cover the basic,
// saturating, single-product and streaming configurations.

module tb_mac_acc_signed;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] out_ready;
  logic [5:0] av [4];
  logic [5:0] bv [4];
  wire  [3:0] in_ready;
  wire  [3:0] out_valid;
  wire  [3:0] ovf;
  wire  [15:0] q0;
  wire  [11:0] q1;
  wire  [15:0] q2;
  wire  [15:0] q3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mac_acc_signed #(.DATA_WIDTH(6), .ACC_LENGTH(4), .OUT_WIDTH(16)) u0 (
    .CLK(clk), .nRST(rst_n), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .A(av[0]), .B(bv[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
    .Q(q0), .OVF(ovf[0]));

  mac_acc_signed #(.DATA_WIDTH(6), .ACC_LENGTH(4), .OUT_WIDTH(12)) u1 (
    .CLK(clk), .nRST(rst_n), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .A(av[1]), .B(bv[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
    .Q(q1), .OVF(ovf[1]));

  mac_acc_signed #(.DATA_WIDTH(6), .ACC_LENGTH(1), .OUT_WIDTH(16)) u2 (
    .CLK(clk), .nRST(rst_n), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
    .A(av[2]), .B(bv[2]), .OUT_VALID(out_valid[2]), .OUT_READY(out_ready[2]),
    .Q(q2), .OVF(ovf[2]));

  mac_acc_signed #(.DATA_WIDTH(6), .ACC_LENGTH(8), .OUT_WIDTH(16)) u3 (
    .CLK(clk), .nRST(rst_n), .IN_VALID(in_valid[3]), .IN_READY(in_ready[3]),
    .A(av[3]), .B(bv[3]), .OUT_VALID(out_valid[3]), .OUT_READY(out_ready[3]),
    .Q(q3), .OVF(ovf[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [15:0] getQ(input int k);
    case (k)
      0:       return q0;
      1:       return {{4{q1[11]}}, q1};
      2:       return q2;
      default: return q3;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one operand pair and hold it until the stage takes it.
  task automatic applyStimulus(input int k, input int a, input int b, output int acc_cyc);
    logic rdy;
    int   n;
    av[k]       = a[5:0];
    bv[k]       = b[5:0];
    in_valid[k] = 1'b1;
    acc_cyc     = -1;
    for (n = 0; n < 50; n++) begin
      rdy = in_ready[k];
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) checkOutput("accept_timeout", 0, 1);
    in_valid[k] = 1'b0;
  endtask

  initial begin
    int c;
    int h;
    int pulses;
    int lastp;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int k = 0; k < 4; k++) begin
      av[k] = '0;
      bv[k] = '0;
    end

    #12;
    checkOutput("rst_in_ready", in_ready[0], 1);
    checkOutput("rst_out_valid", out_valid[0], 0);
    checkOutput("rst_q", getQ(0), 0);
    checkOutput("rst_ovf", ovf[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame followed by five cycles of backpressure
    applyStimulus(0, 3, 5, c);
    applyStimulus(0, -2, 7, c);
    applyStimulus(0, -32, -32, c);
    applyStimulus(0, 1, -1, c);
    checkOutput("t1_ready_drain", in_ready[0], 0);
    checkOutput("t1_valid_early", out_valid[0], 0);
    @(posedge clk);
    #1;
    checkOutput("t1_valid", out_valid[0], 1);
    checkOutput("t1_q", getQ(0), 1024);
    checkOutput("t1_ovf", ovf[0], 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", out_valid[0], 1);
      checkOutput("bp_ready", in_ready[0], 0);
      checkOutput("bp_q", getQ(0), 1024);
      checkOutput("bp_ovf", ovf[0], 0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    h = cyc;
    checkOutput("hs_valid", out_valid[0], 0);
    checkOutput("hs_ready", in_ready[0], 1);
    applyStimulus(0, 2, 3, c);
    checkOutput("hs_first_accept", c, h + 1);
    applyStimulus(0, 2, 3, c);
    applyStimulus(0, 2, 3, c);
    applyStimulus(0, 2, 3, c);
    @(posedge clk);
    #1;
    checkOutput("t1b_valid", out_valid[0], 1);
    checkOutput("t1b_q", getQ(0), 24);

    // Saturation on the 12-bit output
    out_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1, -32, -32, c);
    @(posedge clk);
    #1;
    checkOutput("sat_pos_valid", out_valid[1], 1);
    checkOutput("sat_pos_q", getQ(1), 2047);
    checkOutput("sat_pos_ovf", ovf[1], 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, -32, 31, c);
    @(posedge clk);
    #1;
    checkOutput("sat_neg_q", getQ(1), -2048);
    checkOutput("sat_neg_ovf", ovf[1], 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 10, 10, c);
    @(posedge clk);
    #1;
    checkOutput("sat_none_q", getQ(1), 400);
    checkOutput("sat_none_ovf", ovf[1], 0);

    // Reset in the middle of a frame
    applyStimulus(0, 31, 31, c);
    applyStimulus(0, 31, 31, c);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", in_ready[0], 1);
    checkOutput("mid_rst_valid", out_valid[0], 0);
    checkOutput("mid_rst_q", getQ(0), 0);
    checkOutput("mid_rst_ovf", ovf[0], 0);
    checkOutput("mid_rst_q_sat", getQ(1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, c);
    @(posedge clk);
    #1;
    checkOutput("post_rst_valid", out_valid[0], 1);
    checkOutput("post_rst_q", getQ(0), 4);

    // Single-product frames after idle cycles
    out_ready[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("idle_ready", in_ready[2], 1);
      checkOutput("idle_valid", out_valid[2], 0);
    end
    applyStimulus(2, -32, 31, c);
    checkOutput("len1_valid_early", out_valid[2], 0);
    @(posedge clk);
    #1;
    checkOutput("len1_valid", out_valid[2], 1);
    checkOutput("len1_q", getQ(2), -992);
    checkOutput("len1_ovf", ovf[2], 0);
    applyStimulus(2, 5, -7, c);
    @(posedge clk);
    #1;
    checkOutput("len1b_q", getQ(2), -35);

    // Continuous streaming: one result every ACC_LENGTH+2 cycles
    av[3]        = 6'd1;
    bv[3]        = 6'd1;
    out_ready[3] = 1'b1;
    in_valid[3]  = 1'b1;
    pulses       = 0;
    lastp        = -1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (out_valid[3]) begin
        pulses++;
        checkOutput("stream_q", getQ(3), 8);
        checkOutput("stream_ovf", ovf[3], 0);
        if (lastp >= 0) checkOutput("stream_period", cyc - lastp, 10);
        lastp = cyc;
      end
    end
    in_valid[3] = 1'b0;
    checkOutput("stream_pulses", pulses, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
